// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store initiator driving the data memory request lines
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_LIMIT  = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [15:0] resp_rdata,
  output logic        busy,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write16,
  output logic [7:0]  mem_write8,
  output logic        mem_R_WR,
  output logic        mem_enable,
  output logic        mem_eightbit,
  input  logic [15:0] mem_read16,
  input  logic [7:0]  mem_read8
);

  // Counter only needs to hold WAIT_CYCLES-1; keep at least one bit.
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  // 17-bit compares so a limit of 64 KiB still works without wrap.
  localparam logic [16:0] LIMIT = 17'(ADDR_LIMIT);
  localparam logic [16:0] LAST  = 17'(ADDR_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic          byte_q;
  logic          signed_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [15:0]   resp_rdata_q;
  logic [15:0]   mem_address_q;
  logic [15:0]   mem_write16_q;
  logic [7:0]    mem_write8_q;
  logic          mem_R_WR_q;
  logic          mem_enable_q;
  logic          mem_eightbit_q;

  logic          fault_d;
  logic [15:0]   rdata_d;

  // Address fault: beyond the populated region, or a word whose second byte would be.
  always_comb begin
    fault_d = ({1'b0, req_addr} >= LIMIT) || (!req_byte && ({1'b0, req_addr} == LAST));
  end

  // Load result formatting from the latched request type; stores return zero.
  always_comb begin
    rdata_d = 16'h0000;
    if (!wr_q) begin
      if (byte_q) begin
        rdata_d = signed_q ? {{8{mem_read8[7]}}, mem_read8} : {8'h00, mem_read8};
      end else begin
        rdata_d = mem_read16;
      end
    end
  end

  // Request sequencer: IDLE accepts, ACCESS holds the memory strobe, RESP pulses completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wr_q           <= 1'b0;
      byte_q         <= 1'b0;
      signed_q       <= 1'b0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= 16'h0000;
      mem_address_q  <= 16'h0000;
      mem_write16_q  <= 16'h0000;
      mem_write8_q   <= 8'h00;
      mem_R_WR_q     <= 1'b1;
      mem_enable_q   <= 1'b1;
      mem_eightbit_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q        <= req_wr;
            byte_q      <= req_byte;
            signed_q    <= req_signed;
            req_ready_q <= 1'b0;
            if (fault_d) begin
              // Faulting request never reaches the memory pins.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 16'h0000;
            end else begin
              state_q        <= ACCESS;
              cnt_q          <= CNT_LOAD;
              mem_enable_q   <= 1'b0;
              mem_R_WR_q     <= !req_wr;
              mem_eightbit_q <= !req_byte;
              mem_address_q  <= req_addr;
              mem_write16_q  <= req_wdata;
              mem_write8_q   <= req_wdata[7:0];
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= rdata_d;
            mem_enable_q <= 1'b1;
            mem_R_WR_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          mem_enable_q <= 1'b1;
          mem_R_WR_q   <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = !req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_address  = mem_address_q;
  assign mem_write16  = mem_write16_q;
  assign mem_write8   = mem_write8_q;
  assign mem_R_WR     = mem_R_WR_q;
  assign mem_enable   = mem_enable_q;
  assign mem_eightbit = mem_eightbit_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed vector bench for mem_access_ctrl at WAIT_CYCLES 1 and 3
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v_1, v_3;
  logic        wr, byt, sgn;
  logic [15:0] addr, wdata;

  logic        rdy_1, rv_1, err_1, busy_1, rw_1, en_1, eb_1;
  logic [15:0] rdata_1, maddr_1, mw16_1, rd16_1;
  logic [7:0]  mw8_1, rd8_1;
  logic        rdy_3, rv_3, err_3, busy_3, rw_3, en_3, eb_3;
  logic [15:0] rdata_3, maddr_3, mw16_3, rd16_3;
  logic [7:0]  mw8_3, rd8_3;

  logic [7:0] mem1 [0:255];
  logic [7:0] mem3 [0:255];

  mem_access_ctrl #(.WAIT_CYCLES(1), .ADDR_LIMIT(128)) u1 (
    .clk(clk), .reset(reset), .req_valid(v_1), .req_ready(rdy_1), .req_wr(wr),
    .req_byte(byt), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv_1), .resp_err(err_1), .resp_rdata(rdata_1), .busy(busy_1),
    .mem_address(maddr_1), .mem_write16(mw16_1), .mem_write8(mw8_1), .mem_R_WR(rw_1),
    .mem_enable(en_1), .mem_eightbit(eb_1), .mem_read16(rd16_1), .mem_read8(rd8_1));

  mem_access_ctrl #(.WAIT_CYCLES(3), .ADDR_LIMIT(128)) u3 (
    .clk(clk), .reset(reset), .req_valid(v_3), .req_ready(rdy_3), .req_wr(wr),
    .req_byte(byt), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv_3), .resp_err(err_3), .resp_rdata(rdata_3), .busy(busy_3),
    .mem_address(maddr_3), .mem_write16(mw16_3), .mem_write8(mw8_3), .mem_R_WR(rw_3),
    .mem_enable(en_3), .mem_eightbit(eb_3), .mem_read16(rd16_3), .mem_read8(rd8_3));

  // Big-endian byte memories behind each controller
  assign rd16_1 = {mem1[maddr_1[7:0]], mem1[maddr_1[7:0] + 8'd1]};
  assign rd8_1  = mem1[maddr_1[7:0]];
  assign rd16_3 = {mem3[maddr_3[7:0]], mem3[maddr_3[7:0] + 8'd1]};
  assign rd8_3  = mem3[maddr_3[7:0]];

  always @(posedge clk) begin
    if (!en_1 && !rw_1) begin
      if (!eb_1) mem1[maddr_1[7:0]] = mw8_1;
      else begin
        mem1[maddr_1[7:0]]        = mw16_1[15:8];
        mem1[maddr_1[7:0] + 8'd1] = mw16_1[7:0];
      end
    end
  end

  always @(posedge clk) begin
    if (!en_3 && !rw_3) begin
      if (!eb_3) mem3[maddr_3[7:0]] = mw8_3;
      else begin
        mem3[maddr_3[7:0]]        = mw16_3[15:8];
        mem3[maddr_3[7:0] + 8'd1] = mw16_3[7:0];
      end
    end
  end

  // Instance selector so one transaction task can drive either controller
  logic        sel3;
  logic        c_rv, c_err, c_rdy, c_rw, c_en, c_eb, c_busy;
  logic [15:0] c_rdata, c_maddr, c_mw16;
  logic [7:0]  c_mw8;
  assign c_rv    = sel3 ? rv_3    : rv_1;
  assign c_err   = sel3 ? err_3   : err_1;
  assign c_rdy   = sel3 ? rdy_3   : rdy_1;
  assign c_rw    = sel3 ? rw_3    : rw_1;
  assign c_en    = sel3 ? en_3    : en_1;
  assign c_eb    = sel3 ? eb_3    : eb_1;
  assign c_busy  = sel3 ? busy_3  : busy_1;
  assign c_rdata = sel3 ? rdata_3 : rdata_1;
  assign c_maddr = sel3 ? maddr_3 : maddr_1;
  assign c_mw16  = sel3 ? mw16_3  : mw16_1;
  assign c_mw8   = sel3 ? mw8_3   : mw8_1;

  typedef struct {
    logic        wr;
    logic        byt;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [13];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One request through the selected controller; checks latency, control lines and response
  task automatic run_vec(input string nm, input vec_t v, input bit w3);
    int wait_n, lat, en_cnt;
    bit ctl_bad;
    sel3   = w3;
    wait_n = w3 ? 3 : 1;
    @(negedge clk);
    wr = v.wr; byt = v.byt; sgn = v.sgn; addr = v.addr; wdata = v.wdata;
    if (w3) v_3 = 1'b1; else v_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_1 = 1'b0; v_3 = 1'b0;
    lat = 0; en_cnt = 0; ctl_bad = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (!c_en) begin
        en_cnt++;
        if (c_rw !== !v.wr || c_eb !== !v.byt || c_maddr !== v.addr) ctl_bad = 1'b1;
        if (v.wr && (c_mw16 !== v.wdata || c_mw8 !== v.wdata[7:0])) ctl_bad = 1'b1;
      end
      if (c_rv) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, lat, v.err ? 1 : wait_n + 1);
    chk({nm, "_err"}, c_err, v.err);
    chk({nm, "_rdata"}, c_rdata, v.rdata);
    chk({nm, "_enable_cycles"}, en_cnt, v.err ? 0 : wait_n);
    chk({nm, "_ctl_lines"}, ctl_bad, 0);
    @(negedge clk);
    chk({nm, "_pulse_end"}, c_rv, 0);
    chk({nm, "_ready_back"}, {c_rdy, c_busy}, 2'b10);
    chk({nm, "_hold"}, {c_err, c_rdata}, {v.err, v.rdata});
  endtask

  logic        en_t  [1:10];
  logic        rv_t  [1:10];
  logic        rdy_t [1:10];
  logic [15:0] rd_t  [1:10];
  int          cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem1[i] = 8'h00; mem3[i] = 8'h00; end
    mem1[8'h00] = 8'h3A; mem1[8'h01] = 8'hDC; mem1[8'h04] = 8'h13; mem1[8'h05] = 8'h42;
    mem1[8'h11] = 8'h77; mem1[8'h7E] = 8'h55; mem1[8'h7F] = 8'h81;

    //          wr    byt   sgn   addr      wdata     err   rdata
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 16'hFFDC};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h00DC};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1342};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 16'h00EF};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'hFFBE};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h007F, 16'h0000, 1'b1, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h007F, 16'h0000, 1'b0, 16'hFF81};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h007E, 16'h0000, 1'b0, 16'h5581};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h12A5, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hA577};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1111, 1'b1, 16'h0000};

    reset = 1'b1; v_1 = 1'b0; v_3 = 1'b0; sel3 = 1'b0;
    wr = 1'b0; byt = 1'b0; sgn = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state of both controllers
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      #1;
      chk($sformatf("reset%0d_ready_busy", s), {c_rdy, c_busy, c_rv}, 3'b100);
      chk($sformatf("reset%0d_mem_ctl", s), {c_en, c_rw, c_eb}, 3'b110);
      chk($sformatf("reset%0d_resp", s), {c_err, c_rdata}, 17'h0);
      chk($sformatf("reset%0d_mem_data", s), {c_maddr, c_mw16, c_mw8}, 40'h0);
    end

    for (int i = 0; i < 13; i++) run_vec($sformatf("w1_v%0d", i), vecs[i], 1'b0);

    // WAIT_CYCLES=3 byte store
    run_vec("w3_bstore", '{1'b1, 1'b1, 1'b0, 16'h0030, 16'h345A, 1'b0, 16'h0000}, 1'b1);
    chk("w3_bstore_mem", mem3[8'h30], 8'h5A);

    // Second request held through busy: store 0xC3 to 0x31, then word load 0x30
    sel3 = 1'b1;
    @(negedge clk);
    wr = 1'b1; byt = 1'b1; sgn = 1'b0; addr = 16'h0031; wdata = 16'h00C3; v_3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; byt = 1'b0; addr = 16'h0030; wdata = 16'h0000;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      en_t[k] = en_3; rv_t[k] = rv_3; rdy_t[k] = rdy_3; rd_t[k] = rdata_3;
      if (k == 6) v_3 = 1'b0;
    end
    cnt = 0;
    for (int k = 1; k <= 5; k++) if (!en_t[k]) cnt++;
    chk("hold_first_enable_cycles", cnt, 3);
    chk("hold_gap_enable_high", {en_t[4], en_t[5]}, 2'b11);
    chk("hold_ready_profile", {rdy_t[4], rdy_t[5], rdy_t[6]}, 3'b010);
    chk("hold_second_enable", {en_t[6], en_t[7], en_t[8], en_t[9]}, 4'b0001);
    cnt = 0;
    for (int k = 1; k <= 10; k++) if (rv_t[k]) cnt++;
    chk("hold_resp_count", cnt, 2);
    chk("hold_resp_slots", {rv_t[4], rv_t[9]}, 2'b11);
    chk("hold_second_rdata", rd_t[9], 16'h5AC3);

    // Reset during the second ACCESS cycle of a word load
    @(negedge clk);
    wr = 1'b0; byt = 1'b0; addr = 16'h0030; v_3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_3 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_idle", {rdy_3, busy_3, en_3, rw_3, rv_3}, 5'b10110);
    chk("rst_mid_outputs", {err_3, rdata_3, maddr_3, eb_3}, 34'h0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv_3 || !en_3) cnt++;
    end
    chk("rst_mid_no_resp", cnt, 0);

    // Reset together with req_valid: request must not be taken
    @(negedge clk);
    reset = 1'b1; v_3 = 1'b1; wr = 1'b0; byt = 1'b1; addr = 16'h0030;
    @(negedge clk);
    reset = 1'b0; v_3 = 1'b0;
    chk("rst_valid_not_taken", {rdy_3, en_3}, 2'b11);
    @(negedge clk);
    chk("rst_valid_still_idle", {rdy_3, en_3, rv_3}, 3'b110);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store initiator in the CPU MEM stage. It drives the data memory's request interface.
- Accepts one byte or word request at a time from the pipeline and sequences the memory control lines (active-low enable, R_WR, eightbit).
- Holds the access for a programmable number of cycles, captures and extends read data, and returns a one-cycle response.
- Rejects out-of-range addresses without touching memory.

Parameters:
- WAIT_CYCLES, 1, number of cycles the memory access is held (legal range ≥1).
- ADDR_LIMIT, 128, size of the populated data region in bytes; valid addresses are 0..ADDR_LIMIT-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request strobe
- req_ready  out  1  high when a request can be accepted
- req_wr  in  1  1 = store, 0 = load
- req_byte  in  1  1 = 8-bit access, 0 = 16-bit access
- req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  16  byte address
- req_wdata  in  16  store data (byte store uses [7:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualified by resp_valid; address fault
- resp_rdata  out  16  qualified by resp_valid and !req_wr of the request; load result
- busy  out  1  stall to pipeline, equal to !req_ready
- mem_address  out  16  to data memory
- mem_write16  out  16  word write data
- mem_write8  out  8  byte write data
- mem_R_WR  out  1  1 = read, 0 = write
- mem_enable  out  1  active-low memory enable
- mem_eightbit  out  1  0 = byte access, 1 = word access
- mem_read16  in  16  memory word read data, big-endian {addr, addr+1}
- mem_read8  in  8  memory byte read data at addr

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All outputs are registered or decoded from state and registered request fields.
- Reset (synchronous, active-high):
  - state = IDLE; req_ready = 1; busy = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_enable = 1, mem_R_WR = 1, mem_address = 0, mem_write16 = 0, mem_write8 = 0, mem_eightbit = 0.
  - Wait counter = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge, latch addr, wr, byte, signed, wdata.
  - Fault check: addr ≥ ADDR_LIMIT, or word access with addr == ADDR_LIMIT-1. On fault go to RESP with err set; no memory access.
  - Otherwise go to ACCESS and load the counter with WAIT_CYCLES-1.
- ACCESS (exactly WAIT_CYCLES cycles):
  - mem_enable = 0.
  - mem_R_WR = !wr.
  - mem_eightbit = !byte.
  - mem_address = latched addr.
  - mem_write16 = wdata; mem_write8 = wdata[7:0].
  - Store data is held stable for the whole window; a repeated write of the same data is harmless.
  - Counter decrements each cycle. At the edge where counter == 0, capture read data and go to RESP.
- Load data capture:
  - Word: resp_rdata = mem_read16.
  - Byte, signed: {{8{mem_read8[7]}}, mem_read8}.
  - Byte, unsigned: {8'h00, mem_read8}.
  - Stores: resp_rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. mem_enable = 1, mem_R_WR = 1 in RESP and IDLE.
- Latency:
  - Request accepted at edge E0 → resp_valid high in cycle E0 + WAIT_CYCLES + 1.
  - Fault → resp_valid in the cycle after E0.
  - Throughput: one request per WAIT_CYCLES + 2 cycles.
- req_ready = 0 in ACCESS and RESP. req_valid is ignored there and nothing is latched; the requester holds the request until accepted.
- resp_rdata and resp_err hold their values after the pulse until the next response.
- Reset mid-ACCESS:
  - Next edge forces IDLE with mem_enable = 1 and all outputs at reset values.
  - No resp_valid is produced.
  - A store may or may not have committed; this is the pipeline's concern.
- Reset asserted together with req_valid: reset wins; the request is not accepted.
- Address arithmetic: no wrap. The controller never presents an address the memory would fold.

Test Plan:
- Memory preloaded 0x00=3A, 0x01=DC. Byte load addr 0x0001, signed → resp_rdata=0xFFDC; unsigned → 0x00DC. resp_valid arrives 2 cycles after acceptance (WAIT_CYCLES=1).
- Word load addr 0x0004 (13,42) → 0x1342. During ACCESS: mem_enable=0, mem_R_WR=1, mem_eightbit=1.
- Word store 0xBEEF to 0x0020, then byte load 0x0021 unsigned → 0x00EF; byte load 0x0020 signed → 0xFFBE.
- Word load addr 0x007F → resp_err=1, resp_rdata=0 one cycle after acceptance; mem_enable never low. Byte load 0x0080 → resp_err=1.
- WAIT_CYCLES=3: store byte 0x5A to 0x0030 → mem_enable low exactly 3 cycles, mem_R_WR=0, mem_eightbit=0. A second req_valid held during busy is accepted only after the following IDLE.
- Reset pulsed in the 2nd ACCESS cycle (WAIT_CYCLES=3) → next cycle IDLE, mem_enable=1, no resp_valid, req_ready=1.
